bsg_transpose_serial: RTL

- Streaming bit-matrix transposer. Accepts a matrix one row per handshake and returns it one column per handshake.
- Each output word is one column of the stored matrix. Output word j, bit r = input row r, bit j. This gives the same bit mapping as the team's combinational transpose, spread over time.
- Sits between narrow serial links and wide parallel datapaths where the full matrix is never available at once.

---
 rtl/bsg_transpose_serial_pkg.sv | 19 +
 rtl/bsg_transpose_serial_bank.sv | 37 +++
 rtl/bsg_transpose_serial_chk.sv | 11 +
 rtl/bsg_transpose_serial.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/bsg_transpose_serial_pkg.sv
// Shared types and helpers for the serial bit-matrix transposer.
package bsg_transpose_serial_pkg;

  typedef enum logic [0:0] {
    eFILL  = 1'b0,
    eDRAIN = 1'b1
  } state_e;

  typedef enum logic [0:0] {
    eEMPTY = 1'b0,
    eFULL  = 1'b1
  } bank_status_e;

  // Counter width for n positions, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_transpose_serial_bank.sv
// One matrix of storage: row-addressed write port, column-addressed read mux.
module bsg_transpose_serial_bank
  import bsg_transpose_serial_pkg::*;
#(
  parameter  int width_p  = 16,
  parameter  int els_p    = 16,
  localparam int row_w_lp = cnt_width(els_p),
  localparam int col_w_lp = cnt_width(width_p)
) (
  input  logic                clk_i,
  input  logic                w_v_i,
  input  logic [row_w_lp-1:0] w_row_i,
  input  logic [width_p-1:0]  w_data_i,
  input  logic [col_w_lp-1:0] r_col_i,
  output logic [els_p-1:0]    r_data_o
);

  logic [width_p-1:0] mem_q [els_p];

  // Row storage; contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    for (int r = 0; r < els_p; r++) begin
      if (w_v_i && (w_row_i == row_w_lp'(r))) begin
        mem_q[r] <= w_data_i;
      end
    end
  end

  // Column r_col_i: bit r comes from row r.
  always_comb begin
    r_data_o = '0;
    for (int r = 0; r < els_p; r++) begin
      r_data_o[r] = mem_q[r][r_col_i];
    end
  end

endmodule

// File: rtl/bsg_transpose_serial_chk.sv
// Protocol checker: the consumer may only take a column that is being offered.
module bsg_transpose_serial_chk (
  input logic clk_i,
  input logic reset_i,
  input logic yumi_i,
  input logic valid_i
);

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> valid_i);

endmodule

// File: rtl/bsg_transpose_serial.sv
// Serial bit-matrix transposer: rows in, columns out (word j, bit r = row r, bit j).
// Define BSG_TRANSPOSE_SERIAL_PINGPONG_EN for two banks with overlapped fill and drain.
module bsg_transpose_serial
  import bsg_transpose_serial_pkg::*;
#(
  parameter int width_p = 16,
  parameter int els_p   = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [els_p-1:0]   data_o,
  output logic               last_o,
  input  logic               yumi_i
);

  localparam int row_w_lp = cnt_width(els_p);
  localparam int col_w_lp = cnt_width(width_p);
  localparam logic [row_w_lp-1:0] row_last_lp = row_w_lp'(els_p - 1);
  localparam logic [col_w_lp-1:0] col_last_lp = col_w_lp'(width_p - 1);

  logic [row_w_lp-1:0] row_cnt_q, row_cnt_d;
  logic [col_w_lp-1:0] col_cnt_q, col_cnt_d;
  logic                accept_s, take_s, fill_done_s, drain_done_s;

  // A stray yumi_i while nothing is offered must not move any state.
  assign accept_s     = v_i & ready_o;
  assign take_s       = yumi_i & v_o;
  assign fill_done_s  = accept_s & (row_cnt_q == row_last_lp);
  assign drain_done_s = take_s & (col_cnt_q == col_last_lp);

  // Row and column position counters, wrapping at the matrix edge.
  always_comb begin
    row_cnt_d = row_cnt_q;
    col_cnt_d = col_cnt_q;
    if (fill_done_s) begin
      row_cnt_d = '0;
    end else if (accept_s) begin
      row_cnt_d = row_cnt_q + row_w_lp'(1);
    end else begin
      row_cnt_d = row_cnt_q;
    end
    if (drain_done_s) begin
      col_cnt_d = '0;
    end else if (take_s) begin
      col_cnt_d = col_cnt_q + col_w_lp'(1);
    end else begin
      col_cnt_d = col_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      row_cnt_q <= '0;
      col_cnt_q <= '0;
    end else begin
      row_cnt_q <= row_cnt_d;
      col_cnt_q <= col_cnt_d;
    end
  end

`ifdef BSG_TRANSPOSE_SERIAL_PINGPONG_EN

  bank_status_e     bank_q [2];
  bank_status_e     bank_d [2];
  logic             wb_q, wb_d, rb_q, rb_d;
  logic [els_p-1:0] rdata_s [2];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    bsg_transpose_serial_bank #(
      .width_p(width_p),
      .els_p  (els_p)
    ) u_bank (
      .clk_i   (clk_i),
      .w_v_i   (accept_s & (wb_q == 1'(b))),
      .w_row_i (row_cnt_q),
      .w_data_i(data_i),
      .r_col_i (col_cnt_q),
      .r_data_o(rdata_s[b])
    );
  end

  // Bank status and pointers; a fill and a drain finishing together touch different banks.
  always_comb begin
    bank_d[0] = bank_q[0];
    bank_d[1] = bank_q[1];
    wb_d      = wb_q;
    rb_d      = rb_q;
    if (fill_done_s) begin
      bank_d[wb_q] = eFULL;
      wb_d         = ~wb_q;
    end else begin
      wb_d = wb_q;
    end
    if (drain_done_s) begin
      bank_d[rb_q] = eEMPTY;
      rb_d         = ~rb_q;
    end else begin
      rb_d = rb_q;
    end
  end

  // Bank status and pointer registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bank_q[0] <= eEMPTY;
      bank_q[1] <= eEMPTY;
      wb_q      <= 1'b0;
      rb_q      <= 1'b0;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      wb_q      <= wb_d;
      rb_q      <= rb_d;
    end
  end

  // Handshake outputs decoded from bank status.
  always_comb begin
    ready_o = (bank_q[wb_q] == eEMPTY);
    v_o     = (bank_q[rb_q] == eFULL);
    data_o  = rdata_s[rb_q];
    if (v_o && (col_cnt_q == col_last_lp)) begin
      last_o = 1'b1;
    end else begin
      last_o = 1'b0;
    end
  end

`else

  state_e           state_q, state_d;
  logic [els_p-1:0] rdata_s;

  bsg_transpose_serial_bank #(
    .width_p(width_p),
    .els_p  (els_p)
  ) u_bank (
    .clk_i   (clk_i),
    .w_v_i   (accept_s),
    .w_row_i (row_cnt_q),
    .w_data_i(data_i),
    .r_col_i (col_cnt_q),
    .r_data_o(rdata_s)
  );

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= eFILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave FILL on the final row, leave DRAIN on the final column.
  always_comb begin
    state_d = state_q;
    case (state_q)
      eFILL: begin
        if (fill_done_s) begin
          state_d = eDRAIN;
        end else begin
          state_d = eFILL;
        end
      end
      eDRAIN: begin
        if (drain_done_s) begin
          state_d = eFILL;
        end else begin
          state_d = eDRAIN;
        end
      end
      default: state_d = eFILL;
    endcase
  end

  // Moore outputs.
  always_comb begin
    ready_o = 1'b0;
    v_o     = 1'b0;
    data_o  = rdata_s;
    case (state_q)
      eFILL: begin
        ready_o = 1'b1;
        v_o     = 1'b0;
      end
      eDRAIN: begin
        ready_o = 1'b0;
        v_o     = 1'b1;
      end
      default: begin
        ready_o = 1'b0;
        v_o     = 1'b0;
      end
    endcase
    if (v_o && (col_cnt_q == col_last_lp)) begin
      last_o = 1'b1;
    end else begin
      last_o = 1'b0;
    end
  end

`endif

  bsg_transpose_serial_chk u_chk (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .yumi_i (yumi_i),
    .valid_i(v_o)
  );

endmodule
